// File: rtl/reg_writeback.sv
`default_nettype none
// ============================================================================
// Module   : reg_writeback
// Brief    : Sole register-file writer; merges ALU results with FIFO-buffered
//            LSU results, squashes overtaken LSU writes, exports busy flags.
// Revision : 1.0
// ============================================================================
module reg_writeback #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_rd,
    input  logic [31:0] alu_data,
    input  logic        lsu_valid,
    output logic        lsu_ready,
    input  logic [4:0]  lsu_rd,
    input  logic [31:0] lsu_data,
    output logic        WriteReg,
    output logic [4:0]  Rd_Addr,
    output logic [31:0] WriteData,
    input  logic [4:0]  rs_q,
    input  logic [4:0]  rt_q,
    output logic        rs_busy,
    output logic        rt_busy
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = c_AW + 1;

    logic [DEPTH-1:0] r_vld;
    logic [4:0]       r_rd   [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_CW-1:0]  r_count;

    logic             r_wr_en;
    logic [4:0]       r_wr_addr;
    logic [31:0]      r_wr_data;

    logic w_alu_sel;
    logic w_pop;
    logic w_push;
    logic w_store;
    logic w_rs_hit;
    logic w_rt_hit;

    // Writes to r0 are architectural no-ops, so they neither win the port nor squash.
    assign w_alu_sel = alu_valid && (alu_rd != 5'd0);
    assign w_pop     = !w_alu_sel && (r_count != '0);
    assign lsu_ready = (r_count < c_CW'(DEPTH));
    assign w_push    = lsu_valid && lsu_ready;
    assign w_store   = w_push && (lsu_rd != 5'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_store) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_store, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // A freshly pushed slot is set last-wins, so a same-edge push is never squashed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_vld <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_store && (r_wr_ptr == c_AW'(i))) begin
                    r_vld[i] <= 1'b1;
                end else if ((w_pop && (r_rd_ptr == c_AW'(i))) ||
                             (w_alu_sel && (r_rd[i] == alu_rd))) begin
                    r_vld[i] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_store) begin
            r_rd[r_wr_ptr]   <= lsu_rd;
            r_data[r_wr_ptr] <= lsu_data;
        end
    end

    // Squashed heads consume the slot but leave address/data holding.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_en   <= 1'b0;
            r_wr_addr <= 5'd0;
            r_wr_data <= 32'd0;
        end else if (w_alu_sel) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= alu_rd;
            r_wr_data <= alu_data;
        end else if (w_pop) begin
            r_wr_en <= r_vld[r_rd_ptr];
            if (r_vld[r_rd_ptr]) begin
                r_wr_addr <= r_rd[r_rd_ptr];
                r_wr_data <= r_data[r_rd_ptr];
            end
        end else begin
            r_wr_en <= 1'b0;
        end
    end

    assign WriteReg  = r_wr_en;
    assign Rd_Addr   = r_wr_addr;
    assign WriteData = r_wr_data;

    always_comb begin
        w_rs_hit = 1'b0;
        w_rt_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i] && (r_rd[i] == rs_q)) w_rs_hit = 1'b1;
            if (r_vld[i] && (r_rd[i] == rt_q)) w_rt_hit = 1'b1;
        end
    end

    // The in-flight output stage counts as busy until the file has actually been written.
    assign rs_busy = (rs_q != 5'd0) && (w_rs_hit || (r_wr_en && (r_wr_addr == rs_q)));
    assign rt_busy = (rt_q != 5'd0) && (w_rt_hit || (r_wr_en && (r_wr_addr == rt_q)));

endmodule
`default_nettype wire

// File: tb/tb_reg_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_writeback
// Brief    : Scoreboard bench for reg_writeback; expected writes are queued at
//            stimulus time and matched against each WriteReg cycle.
// Revision : 1.0
// ============================================================================
module tb_reg_writeback;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        WriteReg;
    logic [4:0]  Rd_Addr;
    logic [31:0] WriteData;
    logic [4:0]  rs_q;
    logic [4:0]  rt_q;
    logic        rs_busy;
    logic        rt_busy;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [36:0] sb_q [$];
    logic [31:0] rf [32];

    reg_writeback #(.DEPTH(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .WriteReg  (WriteReg),
        .Rd_Addr   (Rd_Addr),
        .WriteData (WriteData),
        .rs_q      (rs_q),
        .rt_q      (rt_q),
        .rs_busy   (rs_busy),
        .rt_busy   (rt_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_write(input logic [4:0] rd, input logic [31:0] data);
        sb_q.push_back({rd, data});
    endtask

    // The register file samples at negedge; every write must match the queue head.
    always @(negedge clk) begin
        if (rst && WriteReg) begin
            rf[Rd_Addr] = WriteData;
            if (sb_q.size() == 0) begin
                check("unexpected_write", {27'd0, Rd_Addr, WriteData}, 64'd0);
            end else begin
                logic [36:0] e;
                e = sb_q.pop_front();
                check("wr_addr", {59'd0, Rd_Addr}, {59'd0, e[36:32]});
                check("wr_data", {32'd0, WriteData}, {32'd0, e[31:0]});
            end
        end
    end

    initial begin
        for (int r = 0; r < 32; r++) rf[r] = 32'd0;
        rst = 1'b0; alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
        lsu_valid = 1'b0; lsu_rd = 5'd0; lsu_data = 32'd0; rs_q = 5'd0; rt_q = 5'd0;
        step(); step();
        check("rst_wreg",  {63'd0, WriteReg}, 64'd0);
        check("rst_addr",  {59'd0, Rd_Addr}, 64'd0);
        check("rst_data",  {32'd0, WriteData}, 64'd0);
        check("rst_ready", {63'd0, lsu_ready}, 64'd1);
        rst = 1'b1;
        step();

        // ALU path, then an r0 write that must not reach the file
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        expect_write(5'd5, 32'hDEADBEEF);
        step();
        check("alu_wreg", {63'd0, WriteReg}, 64'd1);
        check("alu_addr", {59'd0, Rd_Addr}, 64'd5);
        check("alu_data", {32'd0, WriteData}, 64'hDEADBEEF);
        alu_rd = 5'd0; alu_data = 32'h123;
        step();
        check("alu_r0_wreg", {63'd0, WriteReg}, 64'd0);

        // Fill the FIFO while the ALU holds the port
        for (int k = 1; k <= 4; k++) begin
            check("fill_ready", {63'd0, lsu_ready}, 64'd1);
            alu_valid = 1'b1; alu_rd = 5'(20 + k); alu_data = 32'hA0 + k;
            lsu_valid = 1'b1; lsu_rd = 5'(k); lsu_data = 32'h100 + k;
            expect_write(5'(20 + k), 32'hA0 + k);
            step();
        end
        check("full_ready", {63'd0, lsu_ready}, 64'd0);
        alu_valid = 1'b0; lsu_valid = 1'b0;
        for (int k = 1; k <= 4; k++) expect_write(5'(k), 32'h100 + k);
        for (int k = 1; k <= 4; k++) begin
            step();
            check("drain_wreg", {63'd0, WriteReg}, 64'd1);
            check("drain_addr", {59'd0, Rd_Addr}, 64'(k));
            if (k == 1) check("drain_ready", {63'd0, lsu_ready}, 64'd1);
        end
        step();
        check("drain_idle", {63'd0, WriteReg}, 64'd0);

        // ALU and FIFO head collide on the same edge
        lsu_valid = 1'b1; lsu_rd = 5'd8; lsu_data = 32'h80;
        step();
        check("prio_push_idle", {63'd0, WriteReg}, 64'd0);
        lsu_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h70;
        expect_write(5'd7, 32'h70);
        expect_write(5'd8, 32'h80);
        step();
        check("prio_alu_addr", {59'd0, Rd_Addr}, 64'd7);
        alu_valid = 1'b0;
        step();
        check("prio_fifo_addr", {59'd0, Rd_Addr}, 64'd8);
        step();

        // Squash of a queued load by a younger ALU write
        lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h11;
        step();
        lsu_valid = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h22;
        expect_write(5'd9, 32'h22);
        step();
        alu_valid = 1'b0;
        step();
        check("squash_bubble", {63'd0, WriteReg}, 64'd0);
        step();
        check("squash_r9", {32'd0, rf[9]}, 64'h22);

        // Same-edge push survives the squash
        lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h11;
        step();
        lsu_data = 32'h33;
        alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h22;
        expect_write(5'd9, 32'h22);
        expect_write(5'd9, 32'h33);
        step();
        alu_valid = 1'b0; lsu_valid = 1'b0;
        step();
        check("squash2_bubble", {63'd0, WriteReg}, 64'd0);
        step();
        check("squash2_data", {32'd0, WriteData}, 64'h33);
        step();
        check("squash2_r9", {32'd0, rf[9]}, 64'h33);

        // Busy tracking
        rs_q = 5'd12; rt_q = 5'd0;
        check("busy_pre", {63'd0, rs_busy}, 64'd0);
        lsu_valid = 1'b1; lsu_rd = 5'd12; lsu_data = 32'hC;
        step();
        check("busy_queued", {63'd0, rs_busy}, 64'd1);
        check("busy_rt_zero", {63'd0, rt_busy}, 64'd0);
        lsu_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            alu_valid = 1'b1; alu_rd = 5'd13; alu_data = 32'hD0 + k;
            expect_write(5'd13, 32'hD0 + k);
            step();
            check("busy_stalled", {63'd0, rs_busy}, 64'd1);
        end
        alu_valid = 1'b0;
        expect_write(5'd12, 32'hC);
        step();
        check("busy_in_output", {63'd0, rs_busy}, 64'd1);
        step();
        check("busy_retired", {63'd0, rs_busy}, 64'd0);

        // Asynchronous reset with entries queued
        rs_q = 5'd1;
        for (int k = 1; k <= 3; k++) begin
            alu_valid = 1'b1; alu_rd = 5'd30; alu_data = 32'hE0 + k;
            lsu_valid = 1'b1; lsu_rd = 5'(k); lsu_data = 32'h200 + k;
            if (k < 3) expect_write(5'd30, 32'hE0 + k);
            step();
        end
        alu_valid = 1'b0; lsu_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("arst_wreg",  {63'd0, WriteReg}, 64'd0);
        check("arst_ready", {63'd0, lsu_ready}, 64'd1);
        check("arst_busy",  {63'd0, rs_busy}, 64'd0);
        step(); step();
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            step();
            check("post_rst_idle", {63'd0, WriteReg}, 64'd0);
        end
        check("sb_empty", 64'(sb_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/reg_writeback.md
# reg_writeback

Write-back sequencer that is the sole writer of the 32×32 MIPS register file. It merges single-cycle ALU results with variable-latency load/multi-cycle (LSU) results, buffers LSU results in a small FIFO, and issues at most one register-file write per cycle on the file's WriteReg/Rd_Addr/WriteData port. It also squashes stale LSU results that a younger ALU write has overtaken, and exports per-register busy flags for the decode-stage stall logic.

## Interface
- DEPTH, 4, LSU result FIFO entries (power of two, 2..16)
- clk  in  1  clock; state updates on posedge
- rst  in  1  reset, asynchronous, active-low
- alu_valid  in  1  ALU result present this cycle (never back-pressured)
- alu_rd  in  5  ALU destination register
- alu_data  in  32  ALU result
- lsu_valid  in  1  LSU result offered
- lsu_ready  out  1  FIFO can accept; transfer when lsu_valid & lsu_ready at posedge
- lsu_rd  in  5  LSU destination register
- lsu_data  in  32  LSU result
- WriteReg  out  1  register-file write enable (registered)
- Rd_Addr  out  5  register-file write address (registered)
- WriteData  out  32  register-file write data (registered)
- rs_q, rt_q  in  5 each  busy-query addresses from decode
- rs_busy, rt_busy  out  1 each  queried register has an un-retired LSU write

## Operation
- Output stage: one register holding {WriteReg, Rd_Addr, WriteData}; reloaded every posedge.
- Selection per posedge, priority order:
  1. alu_valid & alu_rd≠0 → output stage loads ALU result, WriteReg=1.
  2. else FIFO non-empty → pop head; if head entry valid, load it with WriteReg=1; if squashed, WriteReg=0 (slot consumed).
  3. else WriteReg=0; Rd_Addr/WriteData hold previous values.
- alu_valid with alu_rd=0: no write; counts as idle, so FIFO may drain that cycle.
- LSU push: lsu_ready = (count < DEPTH), from registered count only; a full FIFO popping this cycle still shows lsu_ready=0. lsu_rd=0 results are accepted (handshake completes) but not stored.
- Each FIFO entry: {valid, rd, data}. Squash: when an ALU write to rd=X≠0 is selected, every entry already in the FIFO with rd=X has valid cleared. An LSU entry pushed in the same posedge is not squashed.
- Squashed entries still occupy FIFO slots until popped.
- Busy: rs_busy = (rs_q≠0) & (any valid FIFO entry with rd=rs_q, or WriteReg & Rd_Addr=rs_q); rt_busy likewise. Combinational from registered state.
- Pointers wrap modulo DEPTH; count is clog2(DEPTH)+1 bits.

## Timing
- Reset (rst=0, async): WriteReg=0, Rd_Addr=0, WriteData=0, FIFO empty, all entry valid bits 0, lsu_ready=1, busy flags 0. Reset mid-operation discards all buffered results with no write issued.
- Outputs change only at posedge, so they are stable at the negedge where the register file samples them.
- ALU latency: sampled at posedge N → WriteReg=1 during cycle N+1 → file written at negedge of cycle N+1.
- LSU latency: pushed at posedge N → earliest pop at posedge N+1 → written during cycle N+2. Each ALU write present at a posedge delays the drain by one cycle.
- Busy drops in the cycle after the output stage retires the entry, i.e. the first cycle in which the file read returns the new value.
- Throughput: one write per cycle; sustained alu_valid stalls the FIFO indefinitely.

## Test plan
- Reset: assert rst=0 mid-stream with 3 entries queued → WriteReg=0, lsu_ready=1, rs_busy=0 immediately; no queued write appears after release.
- ALU path: alu_valid, rd=5, data=0xDEADBEEF at posedge N → cycle N+1: WriteReg=1, Rd_Addr=5, WriteData=0xDEADBEEF; rd=0 → WriteReg=0.
- LSU path and fill: push 4 LSU results (rd 1..4) while alu_valid=1 continuously → lsu_ready=0 after the 4th; drop alu_valid → writes rd 1,2,3,4 in order on consecutive cycles; lsu_ready=1 again one cycle after the first pop.
- Priority collision: alu_valid (rd=7) and non-empty FIFO on the same posedge → ALU write first, FIFO head written next cycle.
- Squash: FIFO holds rd=9 data=0x11, then ALU writes rd=9 data=0x22 → file receives 0x22, squashed slot gives one WriteReg=0 cycle, final r9=0x22; same-cycle LSU push rd=9 data=0x33 → later written, final r9=0x33.
- Busy: LSU push rd=12, rs_q=12 → rs_busy=1 from cycle N+1 until the cycle after its write; rs_q=0 → rs_busy=0 always.
